isp_dvp_tx: RTL and testbench

- Transmitter end of the pipeline's href/vsync/raw pixel interface.
- Accepts raster-order Bayer pixels over a valid/ready stream and buffers them in an internal FIFO.
- Regenerates DVP timing from them: vsync pulse, back porch, active lines with horizontal blanking, front porch.
- Used as the frame source feeding isp_* stages in simulation and on-chip replay paths.

---
 rtl/isp_dvp_pkg.sv | 41 ++++
 rtl/isp_sync_fifo.sv | 71 +++++++
 rtl/isp_dvp_tx.sv | 188 ++++++++++++++++++
 tb/tb_isp_dvp_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_dvp_pkg.sv
// Shared definitions for the DVP transmitter: FSM encoding, default line
// geometry and small constant helpers used to size counters.
package isp_dvp_pkg;

  // Frame generator states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_WAIT,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFP
  } dvp_state_e;

  // Default production geometry: one line period is the active pixels plus
  // the horizontal blanking that follows them.
  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HBLANK = 160;
  localparam int LT         = DEF_WIDTH + DEF_HBLANK;

  // Bits needed to hold the values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

  // Largest of three line-count parameters, used to size the shared v counter.
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/isp_sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy count.
// A read and a write may happen in the same cycle; readiness comes from the
// registered count, so a full FIFO refuses a write even while it is read.
import isp_dvp_pkg::*;

module isp_sync_fifo #(
  parameter int BITS    = 8,
  parameter int FIFO_AW = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [BITS-1:0]    wr_data_i,
  input  logic               rd_en_i,
  output logic [BITS-1:0]    rd_data_o,
  output logic [FIFO_AW:0]   count_o
);

  localparam int Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DepthC = (FIFO_AW+1)'(Depth);

  logic [BITS-1:0]    mem_q [Depth];
  logic [FIFO_AW-1:0] wrPtr_q, wrPtr_d;
  logic [FIFO_AW-1:0] rdPtr_q, rdPtr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [BITS-1:0]    rdData_q;
  logic               wrFire;
  logic               rdFire;

  assign wr_ready_o = (count_q < DepthC);
  assign wrFire     = wr_valid_i && wr_ready_o;
  assign rdFire     = rd_en_i && (count_q != '0);
  assign rd_data_o  = rdData_q;
  assign count_o    = count_q;

  // Next pointer and occupancy values; pointers wrap naturally at 2^FIFO_AW.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrFire) wrPtr_d = wrPtr_q + 1'b1;
    if (rdFire) rdPtr_d = rdPtr_q + 1'b1;
    case ({wrFire, rdFire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and read-data registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      rdData_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (rdFire) rdData_q <= mem_q[rdPtr_q];
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wrFire) mem_q[wrPtr_q] <= wr_data_i;
  end

endmodule

// File: rtl/isp_dvp_tx.sv
// DVP transmitter: buffers raster-order pixels and replays them with
// regenerated vsync / back porch / href+hblank / front porch timing.
import isp_dvp_pkg::*;

module isp_dvp_tx #(
  parameter int BITS        = 8,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = 960,
  parameter int HBLANK      = LT - DEF_WIDTH,
  parameter int VSYNC_LINES = 2,
  parameter int VBP_LINES   = 4,
  parameter int VFP_LINES   = 4,
  parameter int FIFO_AW     = 11
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            en,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BITS-1:0] s_data,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            frame_done,
  output logic            busy
);

  localparam int LineT = WIDTH + HBLANK;
  localparam int HCW   = clog2(LineT);
  localparam int VCW   = clog2(maxOf3(VSYNC_LINES, VBP_LINES, VFP_LINES));
  localparam int LCW   = clog2(HEIGHT + 1);

  localparam logic [HCW-1:0]   HLast     = HCW'(LineT - 1);
  localparam logic [HCW-1:0]   ActLast   = HCW'(WIDTH - 1);
  localparam logic [HCW-1:0]   BlkLast   = HCW'(HBLANK - 1);
  localparam logic [VCW-1:0]   VsLast    = VCW'(VSYNC_LINES - 1);
  localparam logic [VCW-1:0]   VbpLast   = VCW'(VBP_LINES - 1);
  localparam logic [VCW-1:0]   VfpLast   = VCW'(VFP_LINES - 1);
  localparam logic [LCW-1:0]   LinesAll  = LCW'(HEIGHT);
  localparam logic [FIFO_AW:0] LineWords = (FIFO_AW+1)'(WIDTH);

  dvp_state_e       state_q, state_d;
  logic [HCW-1:0]   hcnt_q, hcnt_d;
  logic [VCW-1:0]   vcnt_q, vcnt_d;
  logic [LCW-1:0]   lineCnt_q, lineCnt_d;
  logic             href_q, vsync_q, done_q, busy_q;

  logic [FIFO_AW:0] fifoCount;
  logic [BITS-1:0]  fifoRdData;
  logic             rdEn;
  logic             doneHit;
  logic             haveLine;
  logic             lineEnd;
  logic             periodDone;
  logic [VCW-1:0]   vLastSel;

  isp_sync_fifo #(
    .BITS    (BITS),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_i      (pclk),
    .rst_i      (rst),
    .wr_valid_i (s_valid),
    .wr_ready_o (s_ready),
    .wr_data_i  (s_data),
    .rd_en_i    (rdEn),
    .rd_data_o  (fifoRdData),
    .count_o    (fifoCount)
  );

  assign haveLine = (fifoCount >= LineWords);
  assign lineEnd  = (hcnt_q == HLast);

  // Pick the line budget of whichever multi-line blanking state is current.
  always_comb begin
    vLastSel = VfpLast;
    case (state_q)
      ST_VSYNC: vLastSel = VsLast;
      ST_VBP:   vLastSel = VbpLast;
      default:  vLastSel = VfpLast;
    endcase
  end

  assign periodDone = lineEnd && (vcnt_q == vLastSel);

  // Next-state logic: walks the frame and only starts a line once a whole
  // line of pixels is buffered, so href is never broken mid-line.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    lineCnt_d = lineCnt_q;
    rdEn      = 1'b0;
    doneHit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hcnt_d    = '0;
        vcnt_d    = '0;
        lineCnt_d = '0;
        if (en && haveLine) state_d = ST_VSYNC;
      end

      ST_VSYNC, ST_VBP, ST_VFP: begin
        if (periodDone) begin
          hcnt_d = '0;
          vcnt_d = '0;
          case (state_q)
            ST_VSYNC: state_d = ST_VBP;
            ST_VBP:   state_d = haveLine ? ST_ACTIVE : ST_WAIT;
            default: begin
              doneHit   = 1'b1;
              lineCnt_d = '0;
              state_d   = (en && haveLine) ? ST_VSYNC : ST_IDLE;
            end
          endcase
        end else if (lineEnd) begin
          hcnt_d = '0;
          vcnt_d = vcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      ST_WAIT: begin
        hcnt_d = '0;
        if (haveLine) state_d = ST_ACTIVE;
      end

      ST_ACTIVE: begin
        rdEn = 1'b1;
        if (hcnt_q == ActLast) begin
          hcnt_d    = '0;
          lineCnt_d = lineCnt_q + 1'b1;
          state_d   = ST_HBLANK;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      ST_HBLANK: begin
        if (hcnt_q == BlkLast) begin
          hcnt_d = '0;
          if (lineCnt_q < LinesAll) state_d = haveLine ? ST_ACTIVE : ST_WAIT;
          else                      state_d = ST_VFP;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
        vcnt_d  = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      lineCnt_q <= '0;
      href_q    <= 1'b0;
      vsync_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      lineCnt_q <= lineCnt_d;
      href_q    <= rdEn;
      vsync_q   <= (state_q == ST_VSYNC);
      done_q    <= doneHit;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign out_href   = href_q;
  assign out_vsync  = vsync_q;
  assign out_raw    = href_q ? fifoRdData : '0;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_isp_dvp_tx.sv
// Self-checking bench for isp_dvp_tx with a tiny 4x2 frame geometry.
module tb_isp_dvp_tx;

  localparam int BITS = 8;

  logic            pclk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            sValid = 1'b0;
  logic            sReady;
  logic [BITS-1:0] sData = '0;
  logic            outHref;
  logic            outVsync;
  logic [BITS-1:0] outRaw;
  logic            frameDone;
  logic            busy;

  typedef struct {
    logic            en;
    logic            href;
    logic            vsync;
    logic [BITS-1:0] raw;
    logic            done;
    logic            busy;
  } vec_t;

  vec_t            vecs[$];
  logic [BITS-1:0] seenPix[$];
  int              checkCount = 0;
  int              errorCount = 0;
  int              rawLowBad = 0;

  // Free-running pixel clock.
  always #5 pclk = ~pclk;

  isp_dvp_tx #(
    .BITS        (BITS),
    .WIDTH       (4),
    .HEIGHT      (2),
    .HBLANK      (3),
    .VSYNC_LINES (1),
    .VBP_LINES   (1),
    .VFP_LINES   (1),
    .FIFO_AW     (3)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .en         (en),
    .s_valid    (sValid),
    .s_ready    (sReady),
    .s_data     (sData),
    .out_href   (outHref),
    .out_vsync  (outVsync),
    .out_raw    (outRaw),
    .frame_done (frameDone),
    .busy       (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic enV, input logic validV, input logic [BITS-1:0] dataV);
    en     = enV;
    sValid = validV;
    sData  = dataV;
  endtask

  // One clock, then sample just after the edge and log any href pixel.
  task automatic tick();
    @(posedge pclk);
    #1;
    if (outHref === 1'b1) seenPix.push_back(outRaw);
    else if (outRaw !== '0) rawLowBad++;
  endtask

  task automatic pushPixels(input logic [BITS-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(en, 1'b1, first + BITS'(i));
      tick();
    end
    applyStimulus(en, 1'b0, '0);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return outHref;
      1:       return outVsync;
      default: return frameDone;
    endcase
  endfunction

  task automatic waitSignal(input string name, input int which, input logic level, input int maxCyc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < maxCyc && !hit; i++) begin
      tick();
      hit = (sel(which) === level);
    end
    checkOutput({name, " reached"}, 32'(hit), 32'd1);
  endtask

  task automatic checkPixels(input string name, input logic [BITS-1:0] first, input int n);
    checkOutput({name, " count"}, seenPix.size(), n);
    for (int i = 0; i < n && i < seenPix.size(); i++)
      checkOutput($sformatf("%s[%0d]", name, i), 32'(seenPix[i]), 32'(first + BITS'(i)));
  endtask

  function automatic void addVec(input logic e, input logic h, input logic v,
                                 input logic [BITS-1:0] r, input logic d, input logic b);
    vecs.push_back('{e, h, v, r, d, b});
  endfunction

  initial begin
    int  acc;
    int  stallBad;
    int  doneCount;
    logic prevDone;
    logic rdy;
    logic rdy7;
    logic rdy8;

    // Expected trace of one full frame with 1..8 preloaded (LT = 7).
    addVec(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) addVec(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) addVec(1, 0, 0, 0, 0, 1);
    for (int p = 1; p <= 4; p++) addVec(1, 1, 0, BITS'(p), 0, 1);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 0, 1);
    for (int p = 5; p <= 8; p++) addVec(1, 1, 0, BITS'(p), 0, 1);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) addVec(1, 0, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0);

    // Reset state.
    tick();
    tick();
    checkOutput("reset state", {outHref, outVsync, outRaw, frameDone, busy, sReady}, 32'h001);
    rst = 1'b0;
    tick();

    // Full frame against the vector table.
    pushPixels(8'd1, 8);
    seenPix.delete();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, 1'b0, '0);
      tick();
      checkOutput($sformatf("vec%0d", i),
                  {outHref, outVsync, outRaw, frameDone, busy},
                  {vecs[i].href, vecs[i].vsync, vecs[i].raw, vecs[i].done, vecs[i].busy});
    end
    seenPix.delete();

    // Starved second line: block waits with href low, then sends it intact.
    pushPixels(8'h11, 6);
    seenPix.delete();
    applyStimulus(1'b1, 1'b0, '0);
    waitSignal("s2 line1 start", 0, 1'b1, 40);
    waitSignal("s2 line1 end", 0, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, '0);
    stallBad = 0;
    repeat (20) begin
      tick();
      if (outHref !== 1'b0 || busy !== 1'b1) stallBad++;
    end
    checkOutput("s2 stall", stallBad, 0);
    applyStimulus(1'b0, 1'b1, 8'h17);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h18);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("s2 gap0", 32'(outHref), 0);
    tick();
    checkOutput("s2 gap1", 32'(outHref), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("s2 line2[%0d]", k), {outHref, outRaw}, {1'b1, 8'h15 + 8'(k)});
    end
    tick();
    checkOutput("s2 line2 end", 32'(outHref), 0);
    waitSignal("s2 done", 2, 1'b1, 30);
    checkPixels("s2 pix", 8'h11, 8);
    tick();
    checkOutput("s2 idle busy", 32'(busy), 0);

    // Fill to full with no reads, then stream through two back-to-back frames.
    seenPix.delete();
    acc = 0;
    rdy7 = 1'b0;
    rdy8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rdy = sReady;
      if (i == 7) rdy7 = rdy;
      if (i == 8) rdy8 = rdy;
      applyStimulus(1'b0, 1'b1, 8'h31 + 8'(acc));
      tick();
      if (rdy) acc++;
    end
    checkOutput("s3 accepted", acc, 8);
    checkOutput("s3 ready at 7", 32'(rdy7), 1);
    checkOutput("s3 ready at 8", 32'(rdy8), 0);
    checkOutput("s3 ready full", 32'(sReady), 0);
    doneCount = 0;
    prevDone = 1'b0;
    for (int i = 0; i < 200 && doneCount < 2; i++) begin
      rdy = sReady;
      applyStimulus(doneCount == 0, acc < 16, 8'h31 + 8'(acc));
      tick();
      if (sValid && rdy) acc++;
      if (prevDone) checkOutput("s3 b2b vsync", {outVsync, busy}, 32'd3);
      prevDone = 1'b0;
      if (frameDone === 1'b1) begin
        doneCount++;
        prevDone = (doneCount == 1);
      end
    end
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("s3 two frames", doneCount, 2);
    checkPixels("s3 pix", 8'h31, 16);
    tick();

    // Reset during the second active line, then a fresh frame.
    pushPixels(8'h51, 8);
    seenPix.delete();
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 60 && seenPix.size() < 6; i++) tick();
    checkOutput("s4 line2 reached", seenPix.size(), 6);
    applyStimulus(1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    checkOutput("s4 reset outs", {outHref, outVsync, busy, outRaw, frameDone, sReady}, 32'h001);
    rst = 1'b0;
    tick();
    seenPix.delete();
    pushPixels(8'h61, 8);
    applyStimulus(1'b1, 1'b0, '0);
    waitSignal("s4 done", 2, 1'b1, 60);
    applyStimulus(1'b0, 1'b0, '0);
    checkPixels("s4 fresh", 8'h61, 8);
    tick();

    // en dropped in VBP: frame still completes, then en restarts from IDLE.
    pushPixels(8'h71, 8);
    seenPix.delete();
    applyStimulus(1'b1, 1'b0, '0);
    waitSignal("s5 vsync rise", 1, 1'b1, 5);
    waitSignal("s5 vsync fall", 1, 1'b0, 12);
    applyStimulus(1'b0, 1'b0, '0);
    waitSignal("s5 done", 2, 1'b1, 60);
    checkPixels("s5 pix", 8'h71, 8);
    tick();
    checkOutput("s5 idle busy", 32'(busy), 0);
    pushPixels(8'h81, 4);
    checkOutput("s5 idle hold", {busy, outVsync}, 0);
    applyStimulus(1'b1, 1'b0, '0);
    tick();
    checkOutput("s5 busy next", {busy, outVsync}, 32'd2);
    tick();
    checkOutput("s5 vsync start", 32'(outVsync), 1);
    applyStimulus(1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    checkOutput("raw zero when href low", rawLowBad, 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  // Safety net in case some wait above never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
